mult_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one 32x32 signed sequential shift-add multiplier between NREQ requesters.
- Multiplier contract:
  - m_start is level-held for the whole operation.
  - Operands must stay stable until the product is captured.
  - m_valid rises K cycles after m_start rises (K=32 for the team multiplier).
  - m_prodt is registered one cycle behind the internal result.
  - m_start must return low for at least one cycle between operations, to reset the multiplier's internal count.
- Sits between the multiplier and the client blocks. Clients never drive the multiplier directly.

---
 rtl/mult_share_arb.sv | 149 ++++++++++++++
 tb/tb_mult_share_arb.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin sequencer sharing one sequential 32x32 signed
// multiplier between NREQ requesters.
module mult_share_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 40
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_mlier,
  input  logic [NREQ*32-1:0]   req_mcand,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [63:0]          prodt_out,
  output logic                 err,
  output logic                 m_start,
  output logic [31:0]          m_mlier,
  output logic [31:0]          m_mcand,
  input  logic                 m_valid,
  input  logic [63:0]          m_prodt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [63:0]       prodt_q, prodt_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic [31:0]       mlier_q, mlier_d;
  logic [31:0]       mcand_q, mcand_d;

  logic              pick_ok;
  logic [PW-1:0]     pick;
  int unsigned       scan_idx;

  // Scan upward from the round-robin pointer, wrapping at NREQ-1.
  always_comb begin
    pick_ok  = 1'b0;
    pick     = '0;
    scan_idx = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = (int'(rr_q) + k) % NREQ;
      if (!pick_ok && req[scan_idx]) begin
        pick_ok = 1'b1;
        pick    = PW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    done_d  = '0;
    prodt_d = prodt_q;
    err_d   = err_q;
    start_d = start_q;
    mlier_d = mlier_q;
    mcand_d = mcand_q;
    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          win_d       = pick;
          mlier_d     = req_mlier[32*int'(pick) +: 32];
          mcand_d     = req_mcand[32*int'(pick) +: 32];
          start_d     = 1'b1;
          gnt_d[pick] = 1'b1;
          cnt_d       = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (m_valid) begin
          state_d = CAPTURE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          start_d = 1'b0;
          state_d = RELEASE;
        end
      end
      CAPTURE: begin
        prodt_d       = m_prodt;
        done_d[win_q] = 1'b1;
        start_d       = 1'b0;
        rr_d          = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
        state_d       = RELEASE;
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      prodt_q <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      mlier_q <= '0;
      mcand_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      prodt_q <= prodt_d;
      err_q   <= err_d;
      start_q <= start_d;
      mlier_q <= mlier_d;
      mcand_q <= mcand_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign prodt_out = prodt_q;
  assign err       = err_q;
  assign m_start   = start_q;
  assign m_mlier   = mlier_q;
  assign m_mcand   = mcand_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb with a behavioural K=32 sequential multiplier.
module tb_mult_share_arb;

  localparam int NREQ = 4;
  localparam int K    = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*32-1:0] req_mlier;
  logic [NREQ*32-1:0] req_mcand;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [63:0]       prodt_out;
  logic              err;
  logic              m_start;
  logic [31:0]       m_mlier;
  logic [31:0]       m_mcand;
  logic              m_valid;
  logic [63:0]       m_prodt;

  int n_checks = 0;
  int n_fail   = 0;
  bit never_valid = 1'b0;
  int mcnt = 0;

  mult_share_arb #(.NREQ(NREQ), .TIMEOUT(40)) dut (
    .clock(clock), .reset(reset), .req(req),
    .req_mlier(req_mlier), .req_mcand(req_mcand),
    .gnt(gnt), .done(done), .prodt_out(prodt_out), .err(err),
    .m_start(m_start), .m_mlier(m_mlier), .m_mcand(m_mcand),
    .m_valid(m_valid), .m_prodt(m_prodt)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return sa * sb;
  endfunction

  // Shared multiplier: valid K cycles after start rises, product registered.
  always @(posedge clock) begin
    if (!m_start) mcnt <= 0;
    else if (mcnt < 1000) mcnt <= mcnt + 1;
    m_prodt <= ref_prod(m_mlier, m_mcand);
  end
  assign m_valid = m_start && (mcnt >= K) && !never_valid;

  // gnt/done exclusivity and one-hotness every cycle.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      n_checks++;
      if ((gnt & done) != 0 || !$onehot0(gnt) || !$onehot0(done)) begin
        n_fail++;
        $display("FAIL onehot: gnt=%b done=%b required one-hot-or-zero and disjoint", gnt, done);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_mlier[32*i +: 32] = a;
    req_mcand[32*i +: 32] = b;
  endtask

  task automatic wait_gnt(output int idx, output int n);
    idx = -1;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      n++;
      if (gnt != 0) begin
        idx = oh_idx(gnt);
        break;
      end
    end
  endtask

  task automatic wait_done(output int idx, output int n);
    idx = -1;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      n++;
      if (done != 0) begin
        idx = oh_idx(done);
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    never_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '1;
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'hDEAD0000 + i, 32'h0000BEEF);
    step();
    step();
    n_checks++;
    if ({gnt, done, err, m_start} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: gnt=%b done=%b err=%b m_start=%b required all 0", gnt, done, err, m_start);
    end
    n_checks++;
    if ({prodt_out, m_mlier, m_mcand} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: prodt=%h mlier=%h mcand=%h required 0", prodt_out, m_mlier, m_mcand);
    end
    req = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int idx, n, hi, lat;
    do_reset();
    set_ops(0, 32'd3, 32'hFFFFFFFB);
    req = 4'b0001;
    wait_gnt(idx, n);
    n_checks++;
    if (idx !== 0 || n !== 1) begin
      n_fail++;
      $display("FAIL single_gnt: idx=%0d lat=%0d required idx=0 lat=1", idx, n);
    end
    req = '0;
    set_ops(0, 32'h1234, 32'h5678);
    hi = m_start ? 1 : 0;
    lat = 0;
    idx = -1;
    for (int c = 0; c < 100; c++) begin
      step();
      lat++;
      if (done != 0) begin
        idx = oh_idx(done);
        break;
      end
      if (m_start) hi++;
    end
    n_checks++;
    if (idx !== 0 || lat !== 34) begin
      n_fail++;
      $display("FAIL single_done: idx=%0d lat=%0d required idx=0 lat=34", idx, lat);
    end
    n_checks++;
    if (prodt_out !== 64'hFFFFFFFFFFFFFFF1) begin
      n_fail++;
      $display("FAIL single_prod: got %h required %h", prodt_out, 64'hFFFFFFFFFFFFFFF1);
    end
    n_checks++;
    if (hi !== 34 || m_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_start: high_cycles=%0d start_at_done=%b required 34 and 0", hi, m_start);
    end
    step();
    n_checks++;
    if (m_start !== 1'b0 || gnt !== '0) begin
      n_fail++;
      $display("FAIL single_idle: m_start=%b gnt=%b required 0 and 0", m_start, gnt);
    end
  endtask

  task automatic test_round_robin();
    int idx, ng, nd, exp;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i * 7), 32'(i + 1));
    req = 4'b1111;
    nd = 0;
    for (int k = 0; k < 5; k++) begin
      exp = k % NREQ;
      wait_gnt(idx, ng);
      n_checks++;
      if (idx !== exp) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %0d required %0d", k, idx, exp);
      end
      if (k > 0) begin
        n_checks++;
        if (nd + ng !== 36) begin
          n_fail++;
          $display("FAIL rr_gap[%0d]: got %0d required 36", k, nd + ng);
        end
      end
      wait_done(idx, nd);
      n_checks++;
      if (idx !== exp || prodt_out !== ref_prod(32'(exp * 7), 32'(exp + 1))) begin
        n_fail++;
        $display("FAIL rr_done[%0d]: idx=%0d prod=%h required idx=%0d prod=%h", k, idx, prodt_out,
                 exp, ref_prod(32'(exp * 7), 32'(exp + 1)));
      end
    end
    req = '0;
  endtask

  task automatic test_wrap();
    int idx, n;
    do_reset();
    set_ops(0, 32'd5, 32'd6);
    set_ops(3, -32'sd7, 32'd9);
    req = 4'b1000;
    wait_gnt(idx, n);
    n_checks++;
    if (idx !== 3) begin
      n_fail++;
      $display("FAIL wrap_g3: got %0d required 3", idx);
    end
    req = 4'b1001;
    wait_done(idx, n);
    n_checks++;
    if (idx !== 3 || prodt_out !== 64'hFFFFFFFFFFFFFFC1) begin
      n_fail++;
      $display("FAIL wrap_d3: idx=%0d prod=%h required 3 ffffffffffffffc1", idx, prodt_out);
    end
    wait_gnt(idx, n);
    n_checks++;
    if (idx !== 0) begin
      n_fail++;
      $display("FAIL wrap_g0: got %0d required 0", idx);
    end
    wait_done(idx, n);
    n_checks++;
    if (idx !== 0 || prodt_out !== 64'd30) begin
      n_fail++;
      $display("FAIL wrap_d0: idx=%0d prod=%h required 0 1e", idx, prodt_out);
    end
    wait_gnt(idx, n);
    n_checks++;
    if (idx !== 3) begin
      n_fail++;
      $display("FAIL wrap_g3b: got %0d required 3", idx);
    end
    req = '0;
    wait_done(idx, n);
  endtask

  task automatic test_timeout();
    int idx, n;
    bit saw_done;
    do_reset();
    set_ops(0, 32'd3, 32'd4);
    req = 4'b0001;
    wait_gnt(idx, n);
    req = '0;
    wait_done(idx, n);
    never_valid = 1'b1;
    set_ops(1, 32'd11, 32'd13);
    req = 4'b0010;
    wait_gnt(idx, n);
    req = '0;
    saw_done = 1'b0;
    for (int off = 1; off <= 41; off++) begin
      step();
      if (done != 0) saw_done = 1'b1;
      if (off == 39) begin
        n_checks++;
        if (err !== 1'b0 || m_start !== 1'b1) begin
          n_fail++;
          $display("FAIL to_before: err=%b m_start=%b required 0 1", err, m_start);
        end
      end
      if (off == 40) begin
        n_checks++;
        if (err !== 1'b1 || m_start !== 1'b0) begin
          n_fail++;
          $display("FAIL to_at40: err=%b m_start=%b required 1 0", err, m_start);
        end
      end
    end
    n_checks++;
    if (saw_done !== 1'b0 || prodt_out !== 64'd12) begin
      n_fail++;
      $display("FAIL to_nodone: saw_done=%b prod=%h required 0 c", saw_done, prodt_out);
    end
    never_valid = 1'b0;
    set_ops(2, -32'sd100, 32'd77);
    req = 4'b0100;
    wait_gnt(idx, n);
    req = '0;
    n_checks++;
    if (idx !== 2) begin
      n_fail++;
      $display("FAIL to_regnt: got %0d required 2", idx);
    end
    wait_done(idx, n);
    n_checks++;
    if (idx !== 2 || n !== 34 || prodt_out !== ref_prod(-32'sd100, 32'd77) || err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_recover: idx=%0d lat=%0d prod=%h err=%b required 2 34 %h 1",
               idx, n, prodt_out, err, ref_prod(-32'sd100, 32'd77));
    end
  endtask

  task automatic test_reset_mid_run();
    int idx, n;
    bit bad;
    do_reset();
    set_ops(0, -32'sd3, 32'd1000);
    req = 4'b0001;
    wait_gnt(idx, n);
    req = '0;
    wait_done(idx, n);
    set_ops(1, 32'd9, 32'd9);
    req = 4'b0010;
    wait_gnt(idx, n);
    req = '0;
    for (int c = 0; c < 10; c++) step();
    reset = 1'b1;
    step();
    n_checks++;
    if ({gnt, done, err, m_start} !== '0 || {prodt_out, m_mlier, m_mcand} !== '0) begin
      n_fail++;
      $display("FAIL midrst_vals: gnt=%b done=%b err=%b start=%b prod=%h mlier=%h mcand=%h required all 0",
               gnt, done, err, m_start, prodt_out, m_mlier, m_mcand);
    end
    reset = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (done != 0 || m_start != 1'b0 || gnt != 0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_quiet: activity after reset got 1 required 0");
    end
    set_ops(2, 32'h00012345, -32'sd2);
    req = 4'b0100;
    wait_gnt(idx, n);
    req = '0;
    wait_done(idx, n);
    n_checks++;
    if (idx !== 2 || n !== 34 || prodt_out !== ref_prod(32'h00012345, -32'sd2)) begin
      n_fail++;
      $display("FAIL midrst_after: idx=%0d lat=%0d prod=%h required 2 34 %h", idx, n, prodt_out,
               ref_prod(32'h00012345, -32'sd2));
    end
  endtask

  task automatic test_operand_change();
    int idx, n;
    do_reset();
    set_ops(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    req = 4'b0001;
    wait_gnt(idx, n);
    req = '0;
    set_ops(0, 32'd7, 32'd9);
    wait_done(idx, n);
    n_checks++;
    if (prodt_out !== 64'h1) begin
      n_fail++;
      $display("FAIL opchg_m1: got %h required 0000000000000001", prodt_out);
    end
    set_ops(1, 32'h80000000, 32'd2);
    req = 4'b0010;
    wait_gnt(idx, n);
    set_ops(1, 32'd5, 32'd5);
    req = '0;
    wait_done(idx, n);
    n_checks++;
    if (prodt_out !== 64'hFFFFFFFF00000000) begin
      n_fail++;
      $display("FAIL opchg_min: got %h required ffffffff00000000", prodt_out);
    end
  endtask

  task automatic test_random();
    int idx, n, w, ptr;
    logic [NREQ-1:0] mask;
    logic [31:0] a [NREQ];
    logic [31:0] b [NREQ];
    logic [63:0] exp_p;
    do_reset();
    ptr = 0;
    for (int it = 0; it < 12; it++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        a[i] = $urandom;
        b[i] = $urandom;
        set_ops(i, a[i], b[i]);
      end
      req = mask;
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && mask[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
      wait_gnt(idx, n);
      n_checks++;
      if (idx !== w) begin
        n_fail++;
        $display("FAIL rnd_gnt[%0d]: got %0d required %0d (mask %b)", it, idx, w, mask);
      end
      exp_p = ref_prod(a[w], b[w]);
      set_ops(w, $urandom, $urandom);
      wait_done(idx, n);
      n_checks++;
      if (idx !== w || n !== 34 || prodt_out !== exp_p) begin
        n_fail++;
        $display("FAIL rnd_done[%0d]: idx=%0d lat=%0d prod=%h required %0d 34 %h", it, idx, n,
                 prodt_out, w, exp_p);
      end
      ptr = (w + 1) % NREQ;
    end
    req = '0;
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    req_mlier = '0;
    req_mcand = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid_run();
    test_operand_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
